// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
// State encoding, counter widths and parameter defaults.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_LATENCY      = 2;
  localparam int unsigned DEF_STARVE_LIMIT = 3;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned STARVE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable down-counter timing one memory transaction.
// Stops at zero; zero_o flags the final busy cycle.
module arb_wait_counter
  import mem_port_arbiter_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // load wins over decrement; never wraps below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // count register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and memory stages onto one shared memory port.
// Data has priority unless fetch has waited STARVE_LIMIT data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LATENCY      = DEF_LATENCY,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  input  logic        DReq,
  input  logic        DWrite,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  input  logic [31:0] MemRData,
  output logic        MemEn,
  output logic        MemWrite,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        IReady,
  output logic [31:0] IRData,
  output logic        DReady,
  output logic [31:0] DRData,
  output logic        IStall,
  output logic        DStall
);

  localparam logic [CNT_W-1:0]    LAT_V = CNT_W'(LATENCY);
  localparam logic [STARVE_W-1:0] SL_V  = STARVE_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0]    ONE_V = CNT_W'(1);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                memen_q, memen_d;
  logic                wr_q, wr_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                iready_q, iready_d;
  logic                dready_q, dready_d;
  logic [31:0]         irdata_q, irdata_d;
  logic [31:0]         drdata_q, drdata_d;

  logic             grant;
  logic             busy;
  logic             i_win;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt;

  assign busy  = (state_q != ST_IDLE);
  assign i_win = IReq & (~DReq | (starve_q == SL_V));

  arb_wait_counter u_wait (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .load_i     (grant),
    .load_val_i (LAT_V),
    .dec_i      (busy),
    .count_o    (cnt),
    .zero_o     (cnt_zero)
  );

  // grant, latch and completion decisions
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    memen_d  = 1'b0;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    iready_d = 1'b0;
    dready_d = 1'b0;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    grant    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_win) begin
          grant    = 1'b1;
          state_d  = ST_BUSY_I;
          memen_d  = 1'b1;
          wr_d     = 1'b0;
          addr_d   = IAddr;
          starve_d = '0;
        end else if (DReq) begin
          grant   = 1'b1;
          state_d = ST_BUSY_D;
          memen_d = 1'b1;
          wr_d    = DWrite;
          addr_d  = DAddr;
          wdata_d = DWData;
          if (IReq && (starve_q < SL_V)) begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end
      end
      ST_BUSY_I: begin
        if (cnt == ONE_V) begin
          iready_d = 1'b1;
          irdata_d = MemRData;
        end
        if (cnt_zero) state_d = ST_IDLE;
      end
      ST_BUSY_D: begin
        if (cnt == ONE_V) begin
          dready_d = 1'b1;
          drdata_d = MemRData;
        end
        if (cnt_zero) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers; reset drops any open transaction
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      memen_q  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      memen_q  <= memen_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      iready_q <= iready_d;
      dready_q <= dready_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  assign MemEn    = memen_q;
  assign MemWrite = (state_q == ST_BUSY_D) & wr_q;
  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign IReady   = iready_q;
  assign IRData   = irdata_q;
  assign DReady   = dready_q;
  assign DRData   = drdata_q;
  assign IStall   = IReq & ~iready_q;
  assign DStall   = DReq & ~dready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Directed scenarios plus a random run against a transaction model.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 2;
  localparam int unsigned SL  = 3;

  logic        Clk;
  logic        Rst;
  logic        IReq;
  logic [31:0] IAddr;
  logic        DReq;
  logic        DWrite;
  logic [31:0] DAddr;
  logic [31:0] DWData;
  logic [31:0] MemRData;
  logic        MemEn;
  logic        MemWrite;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        IReady;
  logic [31:0] IRData;
  logic        DReady;
  logic [31:0] DRData;
  logic        IStall;
  logic        DStall;

  int errors;
  int checks;
  int unsigned cyc;

  mem_port_arbiter #(
    .LATENCY      (LAT),
    .STARVE_LIMIT (SL)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .IReq     (IReq),
    .IAddr    (IAddr),
    .DReq     (DReq),
    .DWrite   (DWrite),
    .DAddr    (DAddr),
    .DWData   (DWData),
    .MemRData (MemRData),
    .MemEn    (MemEn),
    .MemWrite (MemWrite),
    .MemAddr  (MemAddr),
    .MemWData (MemWData),
    .IReady   (IReady),
    .IRData   (IRData),
    .DReady   (DReady),
    .DRData   (DRData),
    .IStall   (IStall),
    .DStall   (DStall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // memory returns a per-cycle pattern; value seen in cycle c
  function automatic logic [31:0] mdata(int unsigned c);
    return 32'h9E37_79B9 * c + 32'h0000_1234;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
    MemRData = mdata(cyc);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    IReq = 1'b0; IAddr = '0;
    DReq = 1'b0; DWrite = 1'b0;
    DAddr = '0; DWData = '0;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (MemEn !== 1'b0) begin errors++; $display("FAIL rst_memen got %b exp 0", MemEn); end
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL rst_memwrite got %b exp 0", MemWrite); end
    checks++; if (IReady !== 1'b0) begin errors++; $display("FAIL rst_iready got %b exp 0", IReady); end
    checks++; if (DReady !== 1'b0) begin errors++; $display("FAIL rst_dready got %b exp 0", DReady); end
    checks++; if (MemAddr !== 32'h0) begin errors++; $display("FAIL rst_memaddr got %h exp 0", MemAddr); end
    checks++; if (MemWData !== 32'h0) begin errors++; $display("FAIL rst_memwdata got %h exp 0", MemWData); end
    checks++; if (IRData !== 32'h0) begin errors++; $display("FAIL rst_irdata got %h exp 0", IRData); end
    checks++; if (DRData !== 32'h0) begin errors++; $display("FAIL rst_drdata got %h exp 0", DRData); end
    checks++; if (IStall !== 1'b0) begin errors++; $display("FAIL rst_istall got %b exp 0", IStall); end
  endtask

  task automatic test_fetch();
    do_reset();
    IReq = 1'b1; IAddr = 32'h0000_0040;
    #1;
    checks++; if (IStall !== 1'b1) begin errors++; $display("FAIL fetch_istall_t got %b exp 1", IStall); end
    tick();
    checks++; if (MemEn !== 1'b1) begin errors++; $display("FAIL fetch_memen_t1 got %b exp 1", MemEn); end
    checks++; if (MemAddr !== 32'h40) begin errors++; $display("FAIL fetch_addr_t1 got %h exp 40", MemAddr); end
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL fetch_wr_t1 got %b exp 0", MemWrite); end
    checks++; if (IStall !== 1'b1) begin errors++; $display("FAIL fetch_istall_t1 got %b exp 1", IStall); end
    tick();
    checks++; if (MemEn !== 1'b0) begin errors++; $display("FAIL fetch_memen_t2 got %b exp 0", MemEn); end
    checks++; if (IReady !== 1'b0) begin errors++; $display("FAIL fetch_iready_t2 got %b exp 0", IReady); end
    checks++; if (IStall !== 1'b1) begin errors++; $display("FAIL fetch_istall_t2 got %b exp 1", IStall); end
    MemRData = 32'h2008_0005;
    tick();
    checks++; if (IReady !== 1'b1) begin errors++; $display("FAIL fetch_iready_t3 got %b exp 1", IReady); end
    checks++; if (IRData !== 32'h2008_0005) begin errors++; $display("FAIL fetch_irdata_t3 got %h exp 20080005", IRData); end
    checks++; if (IStall !== 1'b0) begin errors++; $display("FAIL fetch_istall_t3 got %b exp 0", IStall); end
    IReq = 1'b0;
    tick();
    checks++; if (IReady !== 1'b0) begin errors++; $display("FAIL fetch_iready_t4 got %b exp 0", IReady); end
    checks++; if (IRData !== 32'h2008_0005) begin errors++; $display("FAIL fetch_irdata_hold got %h exp 20080005", IRData); end
  endtask

  task automatic test_priority();
    int unsigned t0;
    bit e_en, e_dr, e_ir;
    do_reset();
    IReq = 1'b1; IAddr = 32'h0000_0080;
    DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h1000_0000;
    t0 = cyc;
    for (int k = 0; k <= 8; k++) begin
      if (k == 4) DReq = 1'b0;
      if (k == 8) IReq = 1'b0;
      #1;
      e_en = (k == 1) || (k == 5);
      e_dr = (k == 3);
      e_ir = (k == 7);
      checks++; if (MemEn !== e_en) begin errors++; $display("FAIL prio_memen k=%0d got %b exp %b", k, MemEn, e_en); end
      checks++; if (DReady !== e_dr) begin errors++; $display("FAIL prio_dready k=%0d got %b exp %b", k, DReady, e_dr); end
      checks++; if (IReady !== e_ir) begin errors++; $display("FAIL prio_iready k=%0d got %b exp %b", k, IReady, e_ir); end
      if (k == 1) begin
        checks++; if (MemAddr !== 32'h1000_0000) begin errors++; $display("FAIL prio_daddr got %h exp 10000000", MemAddr); end
      end
      if (k == 3) begin
        checks++; if (DRData !== mdata(t0 + 2)) begin errors++; $display("FAIL prio_drdata got %h exp %h", DRData, mdata(t0 + 2)); end
        checks++; if (DStall !== 1'b0) begin errors++; $display("FAIL prio_dstall got %b exp 0", DStall); end
      end
      if (k == 5) begin
        checks++; if (MemAddr !== 32'h80) begin errors++; $display("FAIL prio_iaddr got %h exp 80", MemAddr); end
      end
      if (k == 7) begin
        checks++; if (IRData !== mdata(t0 + 6)) begin errors++; $display("FAIL prio_irdata got %h exp %h", IRData, mdata(t0 + 6)); end
      end
      tick();
    end
  endtask

  task automatic test_starve();
    bit kinds [8];
    int ng;
    bit e_i;
    do_reset();
    IReq = 1'b1; IAddr = 32'h0000_0200;
    DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h0000_0300;
    ng = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (MemEn === 1'b1 && ng < 8) begin
        kinds[ng] = (MemAddr === 32'h200);
        ng++;
      end
    end
    checks++; if (ng != 8) begin errors++; $display("FAIL starve_grants got %0d exp 8", ng); end
    for (int i = 0; i < ng; i++) begin
      e_i = (i == 3) || (i == 7);
      checks++; if (kinds[i] !== e_i) begin errors++; $display("FAIL starve_seq i=%0d got fetch=%b exp %b", i, kinds[i], e_i); end
    end
    IReq = 1'b0; DReq = 1'b0;
    tick();
  endtask

  task automatic test_store();
    do_reset();
    DReq = 1'b1; DWrite = 1'b1;
    DAddr = 32'h1000_0004; DWData = 32'hDEAD_BEEF;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) DReq = 1'b0;
      checks++; if ((MemEn & MemWrite) !== (k == 1)) begin errors++; $display("FAIL store_en_wr k=%0d got %b", k, MemEn & MemWrite); end
      checks++; if (MemWrite !== (k <= 3)) begin errors++; $display("FAIL store_wr k=%0d got %b", k, MemWrite); end
      checks++; if (DReady !== (k == 3)) begin errors++; $display("FAIL store_dready k=%0d got %b", k, DReady); end
      if (k <= 3) begin
        checks++; if (MemAddr !== 32'h1000_0004) begin errors++; $display("FAIL store_addr k=%0d got %h exp 10000004", k, MemAddr); end
        checks++; if (MemWData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_wdata k=%0d got %h exp deadbeef", k, MemWData); end
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int unsigned t0;
    do_reset();
    IReq = 1'b1; IAddr = 32'h0000_0040;
    tick();
    tick();
    Rst = 1'b1; IReq = 1'b0;
    tick();
    Rst = 1'b0;
    checks++; if (MemEn !== 1'b0) begin errors++; $display("FAIL rmid_memen got %b exp 0", MemEn); end
    checks++; if (MemAddr !== 32'h0) begin errors++; $display("FAIL rmid_addr got %h exp 0", MemAddr); end
    checks++; if (IRData !== 32'h0) begin errors++; $display("FAIL rmid_irdata got %h exp 0", IRData); end
    checks++; if (IReady !== 1'b0) begin errors++; $display("FAIL rmid_iready got %b exp 0", IReady); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if ((IReady | MemEn) !== 1'b0) begin errors++; $display("FAIL rmid_quiet k=%0d got %b exp 0", k, IReady | MemEn); end
    end
    IReq = 1'b1; IAddr = 32'h0000_0044;
    t0 = cyc;
    tick();
    checks++; if (MemEn !== 1'b1) begin errors++; $display("FAIL rmid_next_en got %b exp 1", MemEn); end
    checks++; if (MemAddr !== 32'h44) begin errors++; $display("FAIL rmid_next_addr got %h exp 44", MemAddr); end
    tick();
    tick();
    checks++; if (IReady !== 1'b1) begin errors++; $display("FAIL rmid_next_iready got %b exp 1", IReady); end
    checks++; if (IRData !== mdata(t0 + 2)) begin errors++; $display("FAIL rmid_next_irdata got %h exp %h", IRData, mdata(t0 + 2)); end
    IReq = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    int unsigned t0;
    do_reset();
    DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h1000_0008;
    t0 = cyc;
    tick();
    checks++; if (MemEn !== 1'b1) begin errors++; $display("FAIL drop_memen got %b exp 1", MemEn); end
    tick();
    DReq = 1'b0;
    #1;
    checks++; if (DStall !== 1'b0) begin errors++; $display("FAIL drop_dstall_t2 got %b exp 0", DStall); end
    tick();
    checks++; if (DReady !== 1'b1) begin errors++; $display("FAIL drop_dready got %b exp 1", DReady); end
    checks++; if (DRData !== mdata(t0 + 2)) begin errors++; $display("FAIL drop_drdata got %h exp %h", DRData, mdata(t0 + 2)); end
    checks++; if (DStall !== 1'b0) begin errors++; $display("FAIL drop_dstall_t3 got %b exp 0", DStall); end
    tick();
    checks++; if (DReady !== 1'b0) begin errors++; $display("FAIL drop_once got %b exp 0", DReady); end
  endtask

  task automatic test_random();
    bit          g_valid, g_i, g_wr, iwin;
    int unsigned g_cyc, free_c;
    int          streak;
    bit          i_act, d_act, dwr, i_prev, d_prev;
    bit          e_en, e_wr, e_ir, e_dr;
    logic [31:0] ia, da, dw;
    logic [31:0] e_addr, e_wdata, e_ir_d, e_dr_d;
    do_reset();
    g_valid = 0; g_i = 0; g_wr = 0; g_cyc = 0;
    free_c = cyc; streak = 0;
    i_act = 0; d_act = 0; dwr = 0; i_prev = 0; d_prev = 0;
    ia = '0; da = '0; dw = '0;
    e_addr = '0; e_wdata = '0; e_ir_d = '0; e_dr_d = '0;
    for (int n = 0; n < 400; n++) begin
      if (i_prev) i_act = 0;
      if (!i_act && $urandom_range(0, 2) != 0) begin
        i_act = 1; ia = $urandom;
      end
      if (d_prev) d_act = 0;
      if (!d_act && $urandom_range(0, 2) != 0) begin
        d_act = 1; da = $urandom; dw = $urandom;
        dwr = 1'($urandom_range(0, 1));
      end
      IReq = i_act; IAddr = ia;
      DReq = d_act; DAddr = da; DWData = dw; DWrite = dwr;
      e_en = g_valid && (cyc == g_cyc + 1);
      e_ir = g_valid && g_i && (cyc == g_cyc + 1 + LAT);
      e_dr = g_valid && !g_i && (cyc == g_cyc + 1 + LAT);
      e_wr = g_valid && !g_i && g_wr && (cyc > g_cyc) && (cyc <= g_cyc + 1 + LAT);
      if (e_ir) e_ir_d = mdata(g_cyc + LAT);
      if (e_dr) e_dr_d = mdata(g_cyc + LAT);
      #1;
      checks++; if (MemEn !== e_en) begin errors++; $display("FAIL rnd_memen c=%0d got %b exp %b", cyc, MemEn, e_en); end
      checks++; if (MemWrite !== e_wr) begin errors++; $display("FAIL rnd_memwrite c=%0d got %b exp %b", cyc, MemWrite, e_wr); end
      checks++; if (IReady !== e_ir) begin errors++; $display("FAIL rnd_iready c=%0d got %b exp %b", cyc, IReady, e_ir); end
      checks++; if (DReady !== e_dr) begin errors++; $display("FAIL rnd_dready c=%0d got %b exp %b", cyc, DReady, e_dr); end
      checks++; if ((IReady & DReady) !== 1'b0) begin errors++; $display("FAIL rnd_both_ready c=%0d got 1 exp 0", cyc); end
      checks++; if (MemAddr !== e_addr) begin errors++; $display("FAIL rnd_addr c=%0d got %h exp %h", cyc, MemAddr, e_addr); end
      checks++; if (MemWData !== e_wdata) begin errors++; $display("FAIL rnd_wdata c=%0d got %h exp %h", cyc, MemWData, e_wdata); end
      checks++; if (IRData !== e_ir_d) begin errors++; $display("FAIL rnd_irdata c=%0d got %h exp %h", cyc, IRData, e_ir_d); end
      checks++; if (DRData !== e_dr_d) begin errors++; $display("FAIL rnd_drdata c=%0d got %h exp %h", cyc, DRData, e_dr_d); end
      checks++; if (IStall !== (i_act && !e_ir)) begin errors++; $display("FAIL rnd_istall c=%0d got %b", cyc, IStall); end
      checks++; if (DStall !== (d_act && !e_dr)) begin errors++; $display("FAIL rnd_dstall c=%0d got %b", cyc, DStall); end
      if (cyc >= free_c && (i_act || d_act)) begin
        iwin = i_act && (!d_act || streak == int'(SL));
        g_valid = 1; g_cyc = cyc; g_i = iwin;
        free_c = cyc + LAT + 2;
        if (iwin) begin
          streak = 0; e_addr = ia; g_wr = 0;
        end else begin
          if (i_act && streak < int'(SL)) streak++;
          e_addr = da; e_wdata = dw; g_wr = dwr;
        end
      end
      i_prev = e_ir;
      d_prev = e_dr;
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    MemRData = '0;
    test_reset();
    test_fetch();
    test_priority();
    test_starve();
    test_store();
    test_reset_mid();
    test_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
